// File: rtl/alu_issue_pkg.sv
// Shared types and encodings for the alu_issue stage: ALU control codes,
// MIPS opcode/funct values, the issued bundle and the skid-buffer states.
package alu_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        reg_write;
    logic        illegal;
  } alu_bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Upstream/downstream handshake and execute-stage bundle of alu_issue.
// master = driver of instructions / consumer of bundles, slave = the stage.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALU_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [4:0]  dest;
  logic        reg_write;
  logic        illegal;

  modport master (
    output in_valid, instr, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, ALU_ctrl, a, b, shamt, dest, reg_write, illegal
  );

  modport slave (
    input  in_valid, instr, rs_data, rt_data, out_ready,
    output in_ready, out_valid, ALU_ctrl, a, b, shamt, dest, reg_write, illegal
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational MIPS opcode/funct decode into an ALU issue bundle.
// ALU_ISSUE_ILLEGAL_EN enables flagging of undecodable instructions.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output alu_bundle_t bundle_o
);

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [31:0] simm_s;
  logic [31:0] zimm_s;
  logic        unused_s;

  assign op_s     = instr_i[31:26];
  assign funct_s  = instr_i[5:0];
  assign simm_s   = sign_ext16(instr_i[15:0]);
  assign zimm_s   = {16'h0000, instr_i[15:0]};
  assign unused_s = ^instr_i[25:21];

  // opcode/funct decode; rd==0 suppresses writeback at the end
  always_comb begin
    bundle_o           = '0;
    bundle_o.ctrl      = ALU_NOP;
    bundle_o.a         = rs_data_i;
    bundle_o.b         = rt_data_i;
    bundle_o.dest      = instr_i[20:16];
    bundle_o.reg_write = 1'b1;
    case (op_s)
      OP_RTYPE: begin
        bundle_o.dest = instr_i[15:11];
        case (funct_s)
          FN_ADD, FN_ADDU: bundle_o.ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: bundle_o.ctrl = ALU_SUB;
          FN_AND:          bundle_o.ctrl = ALU_AND;
          FN_OR:           bundle_o.ctrl = ALU_OR;
          FN_NOR:          bundle_o.ctrl = ALU_NOR;
          FN_SLT:          bundle_o.ctrl = ALU_SLT;
          FN_SLTU:         bundle_o.ctrl = ALU_SLTU;
          FN_SLL: begin
            bundle_o.ctrl  = ALU_SLL;
            bundle_o.shamt = instr_i[10:6];
          end
          FN_SRL: begin
            bundle_o.ctrl  = ALU_SRL;
            bundle_o.shamt = instr_i[10:6];
          end
          FN_SRA: begin
            bundle_o.ctrl  = ALU_SRA;
            bundle_o.shamt = instr_i[10:6];
          end
          FN_JR:   bundle_o.reg_write = 1'b0;
          default: begin
            bundle_o.reg_write = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            bundle_o.illegal = 1'b1;
`endif
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin
        bundle_o.ctrl = ALU_ADD;
        bundle_o.b    = simm_s;
      end
      OP_SW: begin
        bundle_o.ctrl      = ALU_ADD;
        bundle_o.b         = simm_s;
        bundle_o.reg_write = 1'b0;
      end
      OP_SLTI: begin
        bundle_o.ctrl = ALU_SLT;
        bundle_o.b    = simm_s;
      end
      OP_SLTIU: begin
        bundle_o.ctrl = ALU_SLTU;
        bundle_o.b    = simm_s;
      end
      OP_ANDI: begin
        bundle_o.ctrl = ALU_AND;
        bundle_o.b    = zimm_s;
      end
      OP_ORI: begin
        bundle_o.ctrl = ALU_OR;
        bundle_o.b    = zimm_s;
      end
      OP_LUI: begin
        bundle_o.ctrl  = ALU_SLL;
        bundle_o.b     = zimm_s;
        bundle_o.shamt = 5'd16;
      end
      OP_BEQ, OP_BNE: begin
        bundle_o.ctrl      = ALU_SUB;
        bundle_o.reg_write = 1'b0;
      end
      default: begin
        bundle_o.reg_write = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
        bundle_o.illegal = 1'b1;
`endif
      end
    endcase
    bundle_o.reg_write = bundle_o.reg_write & (bundle_o.dest != 5'd0);
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: decodes into a registered output bundle backed by a one-entry
// skid register. Build option ALU_ISSUE_ILLEGAL_EN enables the illegal flag.
module alu_issue
  import alu_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  alu_issue_if.slave bus
);

  skid_state_t state_q, state_d;
  alu_bundle_t out_q, out_d, skid_q, skid_d, dec_s;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        accept_s, drain_s;

  alu_decode u_decode (
    .instr_i   (bus.instr),
    .rs_data_i (bus.rs_data),
    .rt_data_i (bus.rt_data),
    .bundle_o  (dec_s)
  );

  assign accept_s = bus.in_valid & in_ready_q;
  assign drain_s  = out_valid_q & bus.out_ready;

  // skid-buffer next state; flush overrides any accept or drain
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            out_d   = dec_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            out_d = dec_s;
          end else if (accept_s) begin
            skid_d  = dec_s;
            state_d = ST_TWO;
          end else if (drain_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (drain_s) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  // state and bundle registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ALU_ctrl  = out_q.ctrl;
  assign bus.a         = out_q.a;
  assign bus.b         = out_q.b;
  assign bus.shamt     = out_q.shamt;
  assign bus.dest      = out_q.dest;
  assign bus.reg_write = out_q.reg_write;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected bundles are queued when driven and
// compared in order as the stage hands them to the execute side.
module tb_alu_issue;
  import alu_pkg::*;

`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  alu_bundle_t sb[$];

  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  function automatic alu_bundle_t mk(input logic [3:0] c, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] sh,
                                     input logic [4:0] d, input logic wr,
                                     input logic ill);
    alu_bundle_t r;
    r.ctrl = c; r.a = a; r.b = b; r.shamt = sh;
    r.dest = d; r.reg_write = wr; r.illegal = ill;
    return r;
  endfunction

  function automatic alu_bundle_t observed();
    return mk(bus.ALU_ctrl, bus.a, bus.b, bus.shamt, bus.dest, bus.reg_write, bus.illegal);
  endfunction

  // scoreboard: every transfer to execute must match the oldest queued entry
  always @(negedge clk) begin
    alu_bundle_t obs;
    alu_bundle_t exp;
    if (reset === 1'b0 && flush === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      obs = observed();
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h, expected no output", obs);
      end else begin
        exp = sb.pop_front();
        if (obs !== exp) begin
          errors++;
          $display("FAIL bundle_order: got %h, expected %h", obs, exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                      input alu_bundle_t e);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL in_ready_wait: in_ready=%b, expected 1 within 40 cycles", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic issue_one(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                           input alu_bundle_t e);
    send(ins, rs, rt, e);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.ALU_ctrl !== e.ctrl) begin
      errors++;
      $display("FAIL latency: out_valid=%b ctrl=%b, expected 1 and %b", bus.out_valid, bus.ALU_ctrl, e.ctrl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.instr = 32'h0; bus.rs_data = 32'h0; bus.rt_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
    checks++;
    if (observed() !== mk(4'b0000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL reset_bundle: got %h, expected all zero", observed());
    end
  endtask

  task automatic test_decode();
    bus.out_ready = 1'b1;
    issue_one(32'h00221820, 32'd5, 32'd7, mk(4'b0001, 32'd5, 32'd7, 5'd0, 5'd3, 1'b1, 1'b0));
    issue_one(32'h2022FFFC, 32'h10, 32'h99, mk(4'b0001, 32'h10, 32'hFFFFFFFC, 5'd0, 5'd2, 1'b1, 1'b0));
    issue_one(32'h3C051234, 32'h11, 32'h22, mk(4'b0111, 32'h11, 32'h00001234, 5'd16, 5'd5, 1'b1, 1'b0));
    issue_one(32'h000220C3, 32'h0, 32'h80000000, mk(4'b1001, 32'h0, 32'h80000000, 5'd3, 5'd4, 1'b1, 1'b0));
    issue_one(32'h00021882, 32'h1, 32'hF0, mk(4'b1000, 32'h1, 32'hF0, 5'd2, 5'd3, 1'b1, 1'b0));
    issue_one(32'h0022182A, 32'h3, 32'h4, mk(4'b0110, 32'h3, 32'h4, 5'd0, 5'd3, 1'b1, 1'b0));
    issue_one(32'h2C23FFFF, 32'h8, 32'h9, mk(4'b1010, 32'h8, 32'hFFFFFFFF, 5'd0, 5'd3, 1'b1, 1'b0));
    issue_one(32'h3023F0F0, 32'h8, 32'h9, mk(4'b0011, 32'h8, 32'h0000F0F0, 5'd0, 5'd3, 1'b1, 1'b0));
    issue_one(32'h34238001, 32'h8, 32'h9, mk(4'b0100, 32'h8, 32'h00008001, 5'd0, 5'd3, 1'b1, 1'b0));
    issue_one(32'hAC22FFF8, 32'h100, 32'h5, mk(4'b0001, 32'h100, 32'hFFFFFFF8, 5'd0, 5'd2, 1'b0, 1'b0));
    issue_one(32'h10220003, 32'h6, 32'h6, mk(4'b0010, 32'h6, 32'h6, 5'd0, 5'd2, 1'b0, 1'b0));
    issue_one(32'h00220020, 32'h1, 32'h2, mk(4'b0001, 32'h1, 32'h2, 5'd0, 5'd0, 1'b0, 1'b0));
    issue_one(32'h03E00008, 32'h400, 32'h0, mk(4'b0000, 32'h400, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0));
    wait_drain();
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    issue_one(32'hFC000000, 32'h0, 32'h0, mk(4'b0000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, ILL_EXP));
    issue_one(32'h0000003F, 32'h0, 32'h0, mk(4'b0000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, ILL_EXP));
    wait_drain();
  endtask

  task automatic test_backpressure();
    alu_bundle_t e[4];
    for (int i = 0; i < 4; i++)
      e[i] = mk(4'b0001, 32'd100 + i, 32'd300 + 3 * i, 5'd0, 5'd3, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    send(32'h00221820, e[0].a, e[0].b, e[0]);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_one: got %b, expected 1", bus.in_ready);
    end
    send(32'h00221820, e[1].a, e[1].b, e[1]);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_ready_two: in_ready=%b out_valid=%b, expected 0 1", bus.in_ready, bus.out_valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (observed() !== e[0]) begin
        errors++; $display("FAIL bp_hold: got %h, expected %h", observed(), e[0]);
      end
    end
    fork
      begin
        send(32'h00221820, e[2].a, e[2].b, e[2]);
        send(32'h00221820, e[3].a, e[3].b, e[3]);
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int bubbles;
    bubbles = 0;
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'h00221820, 32'd500 + i, 32'd7 * i, mk(4'b0001, 32'd500 + i, 32'd7 * i, 5'd0, 5'd3, 1'b1, 1'b0));
      end
      begin
        @(posedge clk);
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) bubbles++;
        end
      end
    join
    checks++;
    if (bubbles != 0) begin
      errors++; $display("FAIL back_to_back: %0d bubble cycles, expected 0", bubbles);
    end
    wait_drain();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    send(32'h00221820, 32'd1, 32'd2, mk(4'b0001, 32'd1, 32'd2, 5'd0, 5'd3, 1'b1, 1'b0));
    send(32'h00221820, 32'd3, 32'd4, mk(4'b0001, 32'd3, 32'd4, 5'd0, 5'd3, 1'b1, 1'b0));
    bus.in_valid = 1'b1; bus.instr = 32'h00A63822; bus.rs_data = 32'hDEAD; bus.rt_data = 32'hBEEF;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    sb.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_two: out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_dropped: out_valid=%b, expected 0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
    send(32'h00221820, 32'd9, 32'd9, mk(4'b0001, 32'd9, 32'd9, 5'd0, 5'd3, 1'b1, 1'b0));
    bus.in_valid = 1'b1; bus.instr = 32'h00221820; bus.rs_data = 32'hAA; bus.rt_data = 32'hBB;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    sb.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_one: out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    issue_one(32'h00221820, 32'd11, 32'd12, mk(4'b0001, 32'd11, 32'd12, 5'd0, 5'd3, 1'b1, 1'b0));
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(32'h00221820, 32'd21, 32'd22, mk(4'b0001, 32'd21, 32'd22, 5'd0, 5'd3, 1'b1, 1'b0));
    send(32'h3C051234, 32'd23, 32'd24, mk(4'b0111, 32'd23, 32'h1234, 5'd16, 5'd5, 1'b1, 1'b0));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ALU_ctrl !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b ctrl=%b, expected 0 1 0000", bus.out_valid, bus.in_ready, bus.ALU_ctrl);
    end
    bus.out_ready = 1'b1;
    issue_one(32'h00021882, 32'd1, 32'd64, mk(4'b1000, 32'd1, 32'd64, 5'd2, 5'd3, 1'b1, 1'b0));
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage feeding the combinational ALU in the MIPS datapath. It accepts a fetched instruction plus its two register-file read values and decodes opcode/funct into the 4-bit ALU control code. It builds the `a`/`b`/`shamt` operands and the writeback destination, then presents them registered to the execute stage. A valid/ready handshake with a two-entry skid buffer gives full throughput under backpressure, and a flush input squashes wrong-path work on branches.

## Interface
- No parameters; all widths are fixed by the 32-bit MIPS datapath.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous squash of all buffered entries.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage can accept this cycle.
- `instr` in 32: MIPS instruction word.
- `rs_data` in 32: register-file value of `instr[25:21]`.
- `rt_data` in 32: register-file value of `instr[20:16]`.
- `out_valid` out 1: execute-stage bundle valid.
- `out_ready` in 1: execute stage accepts.
- `ALU_ctrl` out 4: ALU operation code.
- `a` out 32: ALU operand a.
- `b` out 32: ALU operand b.
- `shamt` out 5: shift amount.
- `dest` out 5: writeback register.
- `reg_write` out 1: writeback enable.
- `illegal` out 1: undecodable instruction (see Configuration).

## Operation
- ALU_ctrl codes: 0000 nop/jr, 0001 add, 0010 sub, 0011 and, 0100 or, 0101 nor, 0110 slt, 0111 sll, 1000 srl, 1001 sra, 1010 sltu.
- R-type (op 0x00) decoding by funct:
  - 0x20 and 0x21 map to add; 0x22 and 0x23 map to sub; 0x24 and, 0x25 or, 0x27 nor, 0x2A slt, 0x2B sltu.
  - 0x00 sll, 0x02 srl, 0x03 sra: `shamt` = `instr[10:6]`.
  - 0x08 jr: code 0000, `reg_write` 0.
  - Operands: `a` = `rs_data`, `b` = `rt_data`, `dest` = rd.
- I-type decoding by opcode. `dest` = rt and `a` = `rs_data` unless noted.
  - 0x08 and 0x09 map to add, sign-extended immediate.
  - 0x0A slt and 0x0B sltu, sign-extended immediate.
  - 0x0C and, 0x0D or, zero-extended immediate.
  - 0x0F lui: sll with `b` = zero-extended immediate and `shamt` = 16.
  - 0x23 lw: add, sign-extended immediate.
  - 0x2B sw: add, sign-extended immediate, `reg_write` 0.
  - 0x04 and 0x05 (beq/bne): sub with `b` = `rt_data`, `reg_write` 0.
- `shamt` = 0 for every non-shift operation.
- `reg_write` is forced to 0 whenever `dest` == 0.
- Any other opcode or funct decodes to code 0000 with `reg_write` 0.
- Buffering: one output register plus one skid register.
  - Flow-through state is EMPTY → ONE (output register filled) → TWO (skid also filled).
  - Accept occurs on `in_valid & in_ready`. Drain occurs on `out_valid & out_ready`.
  - Accept and drain in the same cycle while in ONE: the new entry replaces the output register, and state stays ONE.
  - Drain from TWO: the skid entry moves into the output register, and state goes to ONE.
  - Entries leave in strict FIFO order.
- `flush`: both entries are invalidated next cycle and state goes to EMPTY. An input presented in the same cycle is dropped. Flush wins over accept and over drain.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
- `in_ready` is a register output, equal to NOT(state == TWO). It has no combinational path from `out_ready`.
- Throughput is one instruction per cycle while `out_ready` stays high.
- Output bundle holds stable while `out_valid & ~out_ready`.
- Reset values: `out_valid` 0, `in_ready` 1, `ALU_ctrl` 0000, `a`/`b` 0, `shamt` 0, `dest` 0, `reg_write` 0, `illegal` 0, state EMPTY.
- Reset mid-operation discards all entries.

## Configuration
- `ALU_ISSUE_ILLEGAL_EN` defined: undecodable instructions raise `illegal` = 1 alongside their code-0000 bundle, travelling with that entry.
- `ALU_ISSUE_ILLEGAL_EN` undefined: the detection logic is removed, `illegal` is tied to 0, and undecodable instructions silently become nops.

## Structure
- Package `alu_pkg` holds:
  - the ALU_ctrl code constants;
  - the opcode and funct constants;
  - a packed bundle typedef {ctrl, a, b, shamt, dest, reg_write, illegal}.
- Sub-module `alu_decode` is purely combinational, mapping instr/rs_data/rt_data to the bundle. The top level holds the skid buffer and control.

## Test plan
- `0x00221820` (add $3,$1,$2) with rs 5, rt 7 → ALU_ctrl 0001, a 5, b 7, dest 3, reg_write 1, one cycle later.
- `0x2022FFFC` (addi $2,$1,-4) → b 0xFFFFFFFC, ALU_ctrl 0001, dest 2.
- `0x3C051234` (lui $5) → ALU_ctrl 0111, b 0x00001234, shamt 16, dest 5.
- `0x000220C3` (sra $4,$2,3) → ALU_ctrl 1001, shamt 3.
- Stream 4 instructions with `out_ready` low:
  - `in_ready` falls after 2 accepts;
  - raising `out_ready` drains them in order;
  - back-to-back streaming afterwards gives no bubbles.
- `flush` asserted while in TWO with `in_valid` high → `out_valid` 0 next cycle, `in_ready` 1, flushed input never appears.
- Opcode 0x3F with `ALU_ISSUE_ILLEGAL_EN` → `illegal` 1 and ALU_ctrl 0000. Without the macro → `illegal` 0.
